// File: rtl/cv32e40p_wb_port_arbiter.sv
// Register-file write-port arbiter: LSU writes win, losing ALU results queue in an
// in-order pending buffer that can be forwarded from and is forced out under starvation.
module cv32e40p_wb_port_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_waddr_i,
    input  logic [31:0] alu_wdata_i,
    output logic        alu_ready_o,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_ready_o,
    input  logic        flush_i,
    input  logic [4:0]  fw_raddr_i,
    output logic        fw_hit_o,
    output logic [31:0] fw_wdata_o,
    output logic        busy_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       buf_addr_q [DEPTH];
    logic [31:0]      buf_data_q [DEPTH];
    logic [DEPTH-1:0] buf_valid_q, buf_valid_d;
    logic [PtrW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [StW-1:0]   starve_q, starve_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;

    logic        not_empty, force_head;
    logic        alu_xfer, lsu_xfer;
    logic        grant_lsu, grant_head, grant_byp, grant_any, push;
    logic [4:0]  grant_addr;
    logic [31:0] grant_data;
    logic        fw_hit;
    logic [31:0] fw_data;

    assign not_empty   = (count_q != '0);
    assign force_head  = (starve_q == StW'(STARVE_LIMIT)) && not_empty;
    assign alu_ready_o = ~rst & (count_q < CntW'(DEPTH));
    assign lsu_ready_o = ~rst & ~force_head;
    assign busy_o      = ~rst & not_empty;

    assign alu_xfer   = alu_valid_i & alu_ready_o;
    assign lsu_xfer   = lsu_valid_i & lsu_ready_o;
    // A flush kills everything ALU-side, including the head, but never the LSU write.
    assign grant_lsu  = lsu_xfer;
    assign grant_head = ~lsu_xfer & not_empty & ~flush_i;
    assign grant_byp  = ~lsu_xfer & ~not_empty & alu_xfer & ~flush_i;
    assign grant_any  = grant_lsu | grant_head | grant_byp;
    assign push       = alu_xfer & ~grant_byp & ~flush_i;

    always_comb begin
        grant_addr = alu_waddr_i;
        grant_data = alu_wdata_i;
        if (grant_lsu) begin
            grant_addr = lsu_waddr_i;
            grant_data = lsu_wdata_i;
        end else if (grant_head) begin
            grant_addr = buf_addr_q[rptr_q];
            grant_data = buf_data_q[rptr_q];
        end
    end

    always_comb begin
        count_d     = count_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        buf_valid_d = buf_valid_q;
        starve_d    = starve_q;
        if (grant_head) begin
            rptr_d              = rptr_q + PtrW'(1);
            buf_valid_d[rptr_q] = 1'b0;
        end
        if (push) begin
            wptr_d              = wptr_q + PtrW'(1);
            buf_valid_d[wptr_q] = 1'b1;
        end
        if (push && !grant_head) begin
            count_d = count_q + CntW'(1);
        end else if (!push && grant_head) begin
            count_d = count_q - CntW'(1);
        end
        if (!not_empty || grant_head) begin
            starve_d = '0;
        end else if (grant_lsu && starve_q != StW'(STARVE_LIMIT)) begin
            starve_d = starve_q + StW'(1);
        end
        if (flush_i) begin
            count_d     = '0;
            rptr_d      = '0;
            wptr_d      = '0;
            buf_valid_d = '0;
            starve_d    = '0;
        end
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_any) begin
            rf_we_d    = (grant_addr != 5'd0);
            rf_waddr_d = grant_addr;
            rf_wdata_d = grant_data;
        end
    end

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PtrW-1:0] idx;
        fw_hit  = 1'b0;
        fw_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rptr_q + PtrW'(i);
            if (buf_valid_q[idx] && buf_addr_q[idx] == fw_raddr_i && fw_raddr_i != 5'd0) begin
                fw_hit  = 1'b1;
                fw_data = buf_data_q[idx];
            end
        end
    end

    assign fw_hit_o   = ~rst & fw_hit;
    assign fw_wdata_o = rst ? 32'd0 : fw_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            rptr_q      <= '0;
            wptr_q      <= '0;
            buf_valid_q <= '0;
            starve_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            count_q     <= count_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            buf_valid_q <= buf_valid_d;
            starve_q    <= starve_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wptr_q] <= alu_waddr_i;
            buf_data_q[wptr_q] <= alu_wdata_i;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

endmodule
